block_mem_scheduler: RTL and testbench
======================================

Name: block_mem_scheduler

Overview:
- Sequences the block memory's multi-cycle commands: LOAD stage, PULL rows, DROP rows.
- Three requesters share the memory's single command port: level loader, paddle/pull logic, and drop timer.
- Latches requests, arbitrates by fixed priority, issues one-cycle enable pulses, and tracks the memory's busy handshake to completion.
- Tells the renderer and collision logic when the memory read ports hold valid data.

Parameters:
- TIMEOUT, 127, max cycles spent in WAIT_BUSY or WAIT_DONE before abort (counter width = clog2(TIMEOUT+1)).
- STAGE_W, 2, width of stage select.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_req  in  1  pulse: load stage load_stage.
- load_stage  in  STAGE_W  stage number, sampled when load_req=1.
- pull_req  in  1  pulse: pull rows.
- drop_req  in  1  pulse: drop rows.
- load_ack, pull_ack, drop_ack  out  1 each  one-cycle pulse on command completion.
- flushed  out  1  one-cycle pulse when a LOAD discards pending PULL/DROP.
- mem_enable  out  1  one-cycle command strobe to block memory.
- mem_func  out  2  01 LOAD, 10 PULL, 11 DROP; 00 when idle.
- mem_stage  out  STAGE_W  stage for LOAD.
- mem_busy  in  1  block memory busy.
- rd_valid  out  1  read ports safe to sample.
- cur_stage  out  STAGE_W  stage of last completed LOAD.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, pending bits 0, state IDLE.
  - After reset deasserts, rd_valid rises once mem_busy=0.
  - error is cleared only by reset.
- Pending latches:
  - Each *_req pulse sets its pending bit.
  - A repeat request while that bit is set merges: no double issue.
  - load_stage is captured on every load_req; last value wins.
- LOAD request (pulse or pending) clears pending PULL/DROP and pulses flushed for one cycle if either was set. A LOAD in flight is never cancelled.
- Priority when choosing in IDLE: LOAD > DROP > PULL. The request inputs are ORed with the pending bits, so a req seen in IDLE at cycle N yields mem_enable in cycle N+1.
- State machine:
  - IDLE: if any request and mem_busy=0, go to ISSUE and clear the chosen pending bit.
  - ISSUE (1 cycle): mem_enable=1, mem_func/mem_stage driven; go to WAIT_BUSY, timeout counter cleared.
  - WAIT_BUSY: wait for mem_busy=1, normally the first cycle; go to WAIT_DONE. On counter==TIMEOUT: set error, go to IDLE, no ack.
  - WAIT_DONE: wait for mem_busy=0 (~60 cycles for 30 rows); go to ACK. Same timeout rule.
  - ACK (1 cycle): pulse the matching ack. If LOAD, cur_stage <= issued stage. Go to IDLE.
- mem_func and mem_stage hold their values from ISSUE through ACK; mem_func is 00 in IDLE.
- rd_valid = (state==IDLE) & ~mem_busy, registered-free combinational.
- Simultaneous events:
  - A request equal to the command in flight arriving during WAIT_*/ACK sets pending and is issued again afterwards.
  - A req in the same cycle as its ack is kept.
  - mem_busy high in IDLE with no issue (external use) blocks issue; rd_valid=0.
- Reset mid-operation: immediate return to IDLE, all pending and outputs cleared. The block memory has its own reset.

Decomposition:
- Shared package: func codes FUNC_IDLE=00, FUNC_LOAD=01, FUNC_PULL=10, FUNC_DROP=11; state encoding IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/ACK; MAXROW=30.
- One natural sub-module: req_latch (pending bit plus merge/clear logic, instantiated three times, LOAD instance with stage register).

Test Plan:
- Reset release, memory model busy 60 cycles after enable. load_req, load_stage=2 at cycle 10 → mem_enable=1, mem_func=01, mem_stage=2 at cycle 11; load_ack exactly 1 cycle after busy falls; cur_stage=2; rd_valid=0 from cycle 11 until after ack.
- pull_req and drop_req in the same cycle → DROP issued first (func=11), then PULL (func=10); drop_ack precedes pull_ack; two enables total.
- pull_req pending while DROP runs, then load_req → flushed pulses once; pull never issued; LOAD issued after DROP ack.
- pull_req three times during a running PULL → exactly one further PULL issued, two pull_acks total.
- Memory model never asserts busy → after TIMEOUT+1 cycles in WAIT_BUSY: error=1, no ack, state IDLE, later requests still served; error stays 1.
- reset asserted in WAIT_DONE → outputs 0 asynchronously, pending cleared; after release no command is issued without a new request.

Source files
------------

// File: rtl/block_mem_scheduler_pkg.sv
// block_mem_scheduler_pkg: command codes, FSM states and sizes shared by the scheduler slice
package block_mem_scheduler_pkg;
  typedef enum logic [1:0] {
    FUNC_IDLE = 2'b00,
    FUNC_LOAD = 2'b01,
    FUNC_PULL = 2'b10,
    FUNC_DROP = 2'b11
  } func_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_e;
  localparam int MAXROW = 30;
endpackage

// File: rtl/block_mem_scheduler_if.sv
// block_mem_scheduler_if: requester, block memory and status signals around the scheduler
interface block_mem_scheduler_if
  import block_mem_scheduler_pkg::*;
#(
  parameter int STAGE_W = 2
);
  logic               load_req, pull_req, drop_req, mem_busy;
  logic [STAGE_W-1:0] load_stage, mem_stage, cur_stage;
  logic               load_ack, pull_ack, drop_ack, flushed;
  logic               mem_enable, rd_valid, error;
  func_e              mem_func;
  modport master (
    output load_req, load_stage, pull_req, drop_req, mem_busy,
    input  load_ack, pull_ack, drop_ack, flushed, mem_enable, mem_func, mem_stage,
           rd_valid, cur_stage, error
  );
  modport slave (
    input  load_req, load_stage, pull_req, drop_req, mem_busy,
    output load_ack, pull_ack, drop_ack, flushed, mem_enable, mem_func, mem_stage,
           rd_valid, cur_stage, error
  );
endinterface

// File: rtl/block_mem_scheduler_req_latch.sv
// block_mem_scheduler_req_latch: pending bit that merges repeat requests until issued or flushed
module block_mem_scheduler_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic clr_i,
  input  logic flush_i,
  output logic pend_o
);
  logic pend_q, pend_d;
  always_comb pend_d = (clr_i | flush_i) ? 1'b0 : (pend_q | req_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  assign pend_o = pend_q;
endmodule

// File: rtl/block_mem_scheduler.sv
// block_mem_scheduler: arbitrates LOAD/DROP/PULL onto the block memory command port
// and tracks its busy handshake to completion with a timeout.
module block_mem_scheduler
  import block_mem_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 127,
  parameter int STAGE_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  block_mem_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e             state_q;
  func_e              func_q;
  logic [CW-1:0]      cnt_q;
  logic [STAGE_W-1:0] stage_q, mstage_q, cur_q, ld_stage;
  logic en_q, lack_q, pack_q, dack_q, flush_q, err_q;
  logic lpend, ppend, dpend, load_any, pull_any, drop_any;
  logic go, sel_load, sel_drop, sel_pull, hs_hit;
  always_comb begin
    load_any = bus.load_req | lpend;
    pull_any = bus.pull_req | ppend;
    drop_any = bus.drop_req | dpend;
    go       = (state_q == IDLE) & ~bus.mem_busy & (load_any | pull_any | drop_any);
    sel_load = go & load_any;
    sel_drop = go & ~load_any & drop_any;
    sel_pull = go & ~load_any & ~drop_any & pull_any;
    ld_stage = bus.load_req ? bus.load_stage : stage_q;
    hs_hit   = (state_q == WAIT_BUSY) == bus.mem_busy;
  end
  block_mem_scheduler_req_latch u_load (.clk(clk), .rst_n(rst_n), .req_i(bus.load_req),
    .clr_i(sel_load), .flush_i(1'b0), .pend_o(lpend));
  block_mem_scheduler_req_latch u_pull (.clk(clk), .rst_n(rst_n), .req_i(bus.pull_req),
    .clr_i(sel_pull), .flush_i(load_any), .pend_o(ppend));
  block_mem_scheduler_req_latch u_drop (.clk(clk), .rst_n(rst_n), .req_i(bus.drop_req),
    .clr_i(sel_drop), .flush_i(load_any), .pend_o(dpend));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      func_q   <= FUNC_IDLE;
      cnt_q    <= '0;
      stage_q  <= '0;
      mstage_q <= '0;
      cur_q    <= '0;
      en_q     <= 1'b0;
      lack_q   <= 1'b0;
      pack_q   <= 1'b0;
      dack_q   <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_q    <= 1'b0;
      lack_q  <= 1'b0;
      pack_q  <= 1'b0;
      dack_q  <= 1'b0;
      flush_q <= load_any & (ppend | dpend);
      if (bus.load_req) stage_q <= bus.load_stage;
      case (state_q)
        IDLE: if (go) begin
          state_q  <= ISSUE;
          en_q     <= 1'b1;
          func_q   <= sel_load ? FUNC_LOAD : sel_drop ? FUNC_DROP : FUNC_PULL;
          mstage_q <= sel_load ? ld_stage : '0;
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
          cnt_q   <= '0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          if (hs_hit) begin
            cnt_q   <= '0;
            state_q <= (state_q == WAIT_BUSY) ? WAIT_DONE : ACK;
            if (state_q == WAIT_DONE) begin
              lack_q <= func_q == FUNC_LOAD;
              pack_q <= func_q == FUNC_PULL;
              dack_q <= func_q == FUNC_DROP;
              if (func_q == FUNC_LOAD) cur_q <= mstage_q;
            end
          end else if (cnt_q == CW'(TIMEOUT)) begin
            // abandoned command: no ack, memory state unknown, flag it until reset
            err_q    <= 1'b1;
            state_q  <= IDLE;
            func_q   <= FUNC_IDLE;
            mstage_q <= '0;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          func_q   <= FUNC_IDLE;
          mstage_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.mem_enable = en_q;
  assign bus.mem_func   = func_q;
  assign bus.mem_stage  = mstage_q;
  assign bus.cur_stage  = cur_q;
  assign bus.load_ack   = lack_q;
  assign bus.pull_ack   = pack_q;
  assign bus.drop_ack   = dack_q;
  assign bus.flushed    = flush_q;
  assign bus.error      = err_q;
  assign bus.rd_valid   = rst_n & (state_q == IDLE) & ~bus.mem_busy;
endmodule

// File: tb/tb_block_mem_scheduler.sv
// tb_block_mem_scheduler: directed checks of arbitration, merging, flushing, timeout and reset
module tb_block_mem_scheduler;
  import block_mem_scheduler_pkg::*;
  logic clk, rst_n, model_on;
  int   bcnt, nchk, errs, flush_n;
  int   en_q[$], ack_q[$];
  block_mem_scheduler_if #(.STAGE_W(2)) bus ();
  block_mem_scheduler #(.TIMEOUT(127), .STAGE_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // memory model: busy for 60 cycles starting the cycle after each enable
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (bus.mem_enable && model_on) bcnt <= 60;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  assign bus.mem_busy = bcnt != 0;
  always @(negedge clk)
    if (rst_n) begin
      if (bus.mem_enable) en_q.push_back(int'(bus.mem_func));
      if (bus.load_ack) ack_q.push_back(1);
      if (bus.pull_ack) ack_q.push_back(2);
      if (bus.drop_ack) ack_q.push_back(3);
      if (bus.flushed) flush_n++;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic l, input logic p, input logic d, input logic [1:0] st);
    @(posedge clk);
    #1;
    bus.load_req = l; bus.pull_req = p; bus.drop_req = d; bus.load_stage = st;
    @(posedge clk);
    #1;
    bus.load_req = 0; bus.pull_req = 0; bus.drop_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int  be, ba, bf;
    logic pb1, pb2, bad_rv, seen;
    nchk = 0; errs = 0; flush_n = 0; model_on = 1;
    rst_n = 0;
    bus.load_req = 0; bus.pull_req = 0; bus.drop_req = 0; bus.load_stage = 0;
    repeat (3) @(negedge clk);
    chk("rst_enable", bus.mem_enable, 0);
    chk("rst_func", bus.mem_func, FUNC_IDLE);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_error", bus.error, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rd_valid_after_reset", bus.rd_valid, 1);
    // single LOAD of stage 2
    pulse(1, 0, 0, 2'd2);
    @(negedge clk);
    chk("load_enable", bus.mem_enable, 1);
    chk("load_func", bus.mem_func, FUNC_LOAD);
    chk("load_stage", bus.mem_stage, 2);
    pb1 = bus.mem_busy; pb2 = 0; bad_rv = bus.rd_valid; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.rd_valid) bad_rv = 1;
      if (bus.load_ack) seen = 1;
      else begin pb2 = pb1; pb1 = bus.mem_busy; end
    end
    chk("load_ack_seen", seen, 1);
    chk("ack_after_busy_fall", {pb2, pb1}, 2'b10);
    chk("rd_valid_low_in_cmd", bad_rv, 0);
    chk("cur_stage_2", bus.cur_stage, 2);
    @(negedge clk);
    chk("rd_valid_after_ack", bus.rd_valid, 1);
    chk("func_idle_after_ack", bus.mem_func, FUNC_IDLE);
    // simultaneous PULL and DROP: DROP first
    be = en_q.size(); ba = ack_q.size(); bf = flush_n;
    pulse(0, 1, 1, 2'd0);
    repeat (170) @(posedge clk);
    @(negedge clk);
    chk("pd_enables", en_q.size() - be, 2);
    chk("pd_first_func", en_q[be], FUNC_DROP);
    chk("pd_second_func", en_q[be+1], FUNC_PULL);
    chk("pd_ack_order", {ack_q[ba][3:0], ack_q[ba+1][3:0]}, 8'h32);
    chk("pd_no_flush", flush_n - bf, 0);
    // pending PULL flushed by LOAD during a DROP
    be = en_q.size(); ba = ack_q.size(); bf = flush_n;
    pulse(0, 0, 1, 2'd0);
    repeat (5) @(posedge clk);
    pulse(0, 1, 0, 2'd0);
    repeat (5) @(posedge clk);
    pulse(1, 0, 0, 2'd1);
    repeat (170) @(posedge clk);
    @(negedge clk);
    chk("flush_count", flush_n - bf, 1);
    chk("flush_enables", en_q.size() - be, 2);
    chk("flush_order", {en_q[be][3:0], en_q[be+1][3:0]}, {4'(FUNC_DROP), 4'(FUNC_LOAD)});
    chk("flush_acks", {ack_q[ba][3:0], ack_q[ba+1][3:0]}, 8'h31);
    chk("cur_stage_1", bus.cur_stage, 1);
    // repeated PULL requests merge into one further PULL
    be = en_q.size(); ba = ack_q.size();
    pulse(0, 1, 0, 2'd0);
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1, 0, 2'd0);
      repeat (3) @(posedge clk);
    end
    repeat (170) @(posedge clk);
    @(negedge clk);
    chk("merge_enables", en_q.size() - be, 2);
    chk("merge_funcs", {en_q[be][3:0], en_q[be+1][3:0]}, {4'(FUNC_PULL), 4'(FUNC_PULL)});
    chk("merge_acks", ack_q.size() - ba, 2);
    // busy never asserted: timeout after TIMEOUT+1 cycles in WAIT_BUSY
    model_on = 0;
    ba = ack_q.size();
    pulse(0, 0, 1, 2'd0);
    repeat (128) @(posedge clk);
    @(negedge clk);
    chk("timeout_not_yet", bus.error, 0);
    chk("timeout_func_held", bus.mem_func, FUNC_DROP);
    @(posedge clk);
    @(negedge clk);
    chk("timeout_error", bus.error, 1);
    chk("timeout_func_idle", bus.mem_func, FUNC_IDLE);
    chk("timeout_rd_valid", bus.rd_valid, 1);
    chk("timeout_no_ack", ack_q.size() - ba, 0);
    model_on = 1;
    pulse(0, 1, 0, 2'd0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("after_timeout_served", ack_q.size() - ba, 1);
    chk("error_sticky", bus.error, 1);
    // asynchronous reset in WAIT_DONE
    pulse(1, 0, 0, 2'd3);
    repeat (20) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_func", bus.mem_func, FUNC_IDLE);
    chk("mid_rst_error", bus.error, 0);
    chk("mid_rst_cur_stage", bus.cur_stage, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    be = en_q.size();
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_issue", en_q.size() - be, 0);
    chk("post_rst_rd_valid", bus.rd_valid, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
    $finish;
  end
endmodule
